// File: rtl/button_event_if.sv
// Button event bus: debounced level in, single-cycle events and press count out.
// master = whoever drives the button level (debouncer / bench),
// slave  = the event FSM.
interface button_event_if;
  logic       btn_in;
  logic       press;
  logic       release_evt;
  logic       short_press;
  logic       long_press;
  logic       repeat_evt;
  logic       held;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    input  press, release_evt, short_press, long_press, repeat_evt, held, press_count
  );

  modport slave (
    input  btn_in,
    output press, release_evt, short_press, long_press, repeat_evt, held, press_count
  );
endinterface

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into press / release / short / long / repeat
// pulses plus a wrapping press counter. All outputs come straight from flops.
module button_event_fsm #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 27
) (
  input  logic            clock,
  input  logic            reset,
  button_event_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;
  logic [7:0]       count_q, count_d;

  // Next-state logic; release always wins over a terminal count on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (bus.btn_in) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
        end
      end
      PRESSED: begin
        if (!bus.btn_in) begin
          state_d   = IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (cnt_q == LONG_TC) begin
          state_d = REPEAT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!bus.btn_in) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (cnt_q == REP_TC) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // held tracks the state being entered so it rises with press and drops with release
    held_d = (state_d != IDLE);
  end

  // State, counter and registered outputs; reset mid-hold drops to IDLE silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      count_q   <= count_d;
    end
  end

  assign bus.press       = press_q;
  assign bus.release_evt = release_q;
  assign bus.short_press = short_q;
  assign bus.long_press  = long_q;
  assign bus.repeat_evt  = repeat_q;
  assign bus.held        = held_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event_fsm;

  typedef struct packed {
    logic       p;   // press
    logic       r;   // release
    logic       s;   // short_press
    logic       l;   // long_press
    logic       rp;  // repeat
    logic       h;   // held
    logic [7:0] c;   // press_count
  } exp_t;

  typedef struct {
    logic rst;
    logic btn;
    exp_t e;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  vec_t tbl[8];

  button_event_if bus();

  button_event_fsm #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(logic p, logic r, logic s, logic l, logic rp, logic h, logic [7:0] c);
    exp_t e;
    e.p = p; e.r = r; e.s = s; e.l = l; e.rp = rp; e.h = h; e.c = c;
    return e;
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic r, input logic b, input exp_t e, input string nm);
    exp_t got, want;
    @(negedge clock);
    reset      = r;
    bus.btn_in = b;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got  = mk(bus.press, bus.release_evt, bus.short_press, bus.long_press,
              bus.repeat_evt, bus.held, bus.press_count);
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t: got p%b r%b s%b l%b rp%b h%b c%0d, want p%b r%b s%b l%b rp%b h%b c%0d",
               nm, $time, got.p, got.r, got.s, got.l, got.rp, got.h, got.c,
               want.p, want.r, want.s, want.l, want.rp, want.h, want.c);
    end
  endtask

  initial begin
    logic [7:0] cnt;
    bus.btn_in = 1'b0;

    // reset state and a 3-cycle press
    tbl[0] = '{1'b1, 1'b0, mk(0,0,0,0,0,0,8'd0)};
    tbl[1] = '{1'b1, 1'b0, mk(0,0,0,0,0,0,8'd0)};
    tbl[2] = '{1'b1, 1'b0, mk(0,0,0,0,0,0,8'd0)};
    tbl[3] = '{1'b0, 1'b1, mk(1,0,0,0,0,1,8'd1)};
    tbl[4] = '{1'b0, 1'b1, mk(0,0,0,0,0,1,8'd1)};
    tbl[5] = '{1'b0, 1'b1, mk(0,0,0,0,0,1,8'd1)};
    tbl[6] = '{1'b0, 1'b0, mk(0,1,1,0,0,0,8'd1)};
    tbl[7] = '{1'b0, 1'b0, mk(0,0,0,0,0,0,8'd1)};
    foreach (tbl[i]) step(tbl[i].rst, tbl[i].btn, tbl[i].e, "table");

    // 20-cycle hold: long at +8, repeats at +12 and +16, release without short
    for (int k = 1; k <= 20; k++)
      step(0, 1, mk(k == 1, 0, 0, k == 9, (k == 13) || (k == 17), 1, 8'd2), "long_hold");
    step(0, 0, mk(0,1,0,0,0,0,8'd2), "long_release");

    // release on the PRESSED terminal-count edge
    for (int k = 1; k <= 8; k++)
      step(0, 1, mk(k == 1, 0, 0, 0, 0, 1, 8'd3), "tc_pressed_hold");
    step(0, 0, mk(0,1,1,0,0,0,8'd3), "tc_pressed_release");
    step(0, 0, mk(0,0,0,0,0,0,8'd3), "tc_pressed_idle");

    // release on the REPEAT terminal-count edge
    for (int k = 1; k <= 12; k++)
      step(0, 1, mk(k == 1, 0, 0, k == 9, 0, 1, 8'd4), "tc_repeat_hold");
    step(0, 0, mk(0,1,0,0,0,0,8'd4), "tc_repeat_release");
    step(0, 0, mk(0,0,0,0,0,0,8'd4), "tc_repeat_idle");

    // 256 single-cycle taps from a fresh count: wraps back to 0
    step(1, 0, mk(0,0,0,0,0,0,8'd0), "wrap_reset");
    for (int i = 0; i < 256; i++) begin
      cnt = 8'(i + 1);
      step(0, 1, mk(1,0,0,0,0,1,cnt), "wrap_press");
      step(0, 0, mk(0,1,1,0,0,0,cnt), "wrap_release");
    end
    step(0, 0, mk(0,0,0,0,0,0,8'd0), "wrap_final");

    // reset during REPEAT with the button held: no release, fresh press after
    step(1, 0, mk(0,0,0,0,0,0,8'd0), "midreset_pre");
    for (int k = 1; k <= 9; k++)
      step(0, 1, mk(k == 1, 0, 0, k == 9, 0, 1, 8'd1), "midreset_hold");
    step(1, 1, mk(0,0,0,0,0,0,8'd0), "midreset_reset");
    for (int k = 1; k <= 9; k++)
      step(0, 1, mk(k == 1, 0, 0, k == 9, 0, 1, 8'd1), "midreset_rehold");
    step(0, 0, mk(0,1,0,0,0,0,8'd1), "midreset_release");
    step(0, 0, mk(0,0,0,0,0,0,8'd1), "midreset_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
